// File: rtl/digit_renderer.sv
// digit_renderer: converts a binary value to decimal digits (shift-and-add-3)
// and renders them as 6x10 glyph pixels through a 2-stage lookup pipeline.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits
// (value 0 then shows a single "0" in the least significant position).
module digit_renderer #(
    parameter int NUM_DIGITS = 4,
    parameter int VALUE_W    = 14,
    localparam int COL_W     = $clog2(6 * NUM_DIGITS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [VALUE_W-1:0] value,
    output logic               busy,
    output logic               overflow,
    input  logic               en,
    input  logic [3:0]         row,
    input  logic [COL_W-1:0]   col,
    output logic               pixel,
    output logic               pixel_valid
);

    localparam int          BCD_W   = 4 * NUM_DIGITS;
    localparam int          CNT_W   = $clog2(VALUE_W + 1);
    localparam logic [31:0] MAX_VAL = 32'(10 ** NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Conversion state
    // ------------------------------------------------------------------
    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [VALUE_W-1:0]   sh_q, sh_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic                 ovf_pend_q, ovf_pend_d;
    logic [BCD_W-1:0]     digits_q, digits_d;
    logic                 overflow_q, overflow_d;
    logic                 busy_q, busy_d;

    logic [BCD_W-1:0]     bcd_adj;
    logic [BCD_W-1:0]     all_nines;

    // Per-nibble add-3 correction and the saturated display pattern.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nibble
            assign bcd_adj[gi*4 +: 4]   = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                          (bcd_q[gi*4 +: 4] + 4'd3) : bcd_q[gi*4 +: 4];
            assign all_nines[gi*4 +: 4] = 4'd9;
        end
    endgenerate

    // Next-state logic of the conversion FSM; display digits only move in COMMIT.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        bcd_d      = bcd_q;
        ovf_pend_d = ovf_pend_q;
        digits_d   = digits_q;
        overflow_d = overflow_q;
        busy_d     = busy_q;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    sh_d       = value;
                    bcd_d      = '0;
                    cnt_d      = '0;
                    ovf_pend_d = (32'(value) > MAX_VAL);
                    busy_d     = 1'b1;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = {bcd_adj[BCD_W-2:0], sh_q[VALUE_W-1]};
                sh_d  = {sh_q[VALUE_W-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(VALUE_W - 1)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                digits_d   = ovf_pend_q ? all_nines : bcd_q;
                overflow_d = ovf_pend_q;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Conversion FSM registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sh_q       <= '0;
            bcd_q      <= '0;
            ovf_pend_q <= 1'b0;
            digits_q   <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            bcd_q      <= bcd_d;
            ovf_pend_q <= ovf_pend_d;
            digits_q   <= digits_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign overflow = overflow_q;

    // ------------------------------------------------------------------
    // Glyph font: 10 rows of 6 bits per digit, row 0 in the top bits,
    // bit 5 of each row is the leftmost glyph column.
    // ------------------------------------------------------------------
    function automatic logic [5:0] font_row(input logic [3:0] d, input logic [3:0] r);
        logic [59:0] g;
        int          idx;
        unique case (d)
            4'd0: g = {6'b111111, 6'b110011, 6'b110011, 6'b110111, 6'b111011,
                       6'b110011, 6'b110011, 6'b110011, 6'b110011, 6'b111111};
            4'd1: g = {6'b111100, 6'b001100, 6'b001100, 6'b001100, 6'b001100,
                       6'b001100, 6'b001100, 6'b001100, 6'b001100, 6'b111111};
            4'd2: g = {6'b111111, 6'b000011, 6'b000011, 6'b000011, 6'b111111,
                       6'b110000, 6'b110000, 6'b110000, 6'b110000, 6'b111111};
            4'd3: g = {6'b111111, 6'b000011, 6'b000011, 6'b000011, 6'b011111,
                       6'b000011, 6'b000011, 6'b000011, 6'b000011, 6'b111111};
            4'd4: g = {6'b110011, 6'b110011, 6'b110011, 6'b110011, 6'b111111,
                       6'b000011, 6'b000011, 6'b000011, 6'b000011, 6'b000011};
            4'd5: g = {6'b111111, 6'b110000, 6'b110000, 6'b110000, 6'b111111,
                       6'b000011, 6'b000011, 6'b000011, 6'b000011, 6'b111111};
            4'd6: g = {6'b111111, 6'b110000, 6'b110000, 6'b110000, 6'b111111,
                       6'b110011, 6'b110011, 6'b110011, 6'b110011, 6'b111111};
            4'd7: g = {6'b111111, 6'b000011, 6'b000011, 6'b000110, 6'b001100,
                       6'b001100, 6'b001100, 6'b001100, 6'b001100, 6'b001100};
            4'd8: g = {6'b111111, 6'b110011, 6'b110011, 6'b110011, 6'b111111,
                       6'b110011, 6'b110011, 6'b110011, 6'b110011, 6'b111111};
            4'd9: g = {6'b111111, 6'b110011, 6'b110011, 6'b110011, 6'b111111,
                       6'b000011, 6'b000011, 6'b000011, 6'b000011, 6'b111111};
            default: g = '0;
        endcase
        if (r <= 4'd9) begin
            idx      = (9 - int'(r)) * 6;
            font_row = g[idx +: 6];
        end else begin
            font_row = 6'b000000;
        end
    endfunction

    // ------------------------------------------------------------------
    // Pixel pipeline
    // ------------------------------------------------------------------
    logic             s1_valid_q, s1_valid_d;
    logic             s1_inrange_q, s1_inrange_d;
    logic [3:0]       s1_row_q, s1_row_d;
    logic [COL_W-1:0] s1_dig_q, s1_dig_d;
    logic [2:0]       s1_gcol_q, s1_gcol_d;
    logic             pixel_q, pixel_d;
    logic             pixel_valid_q, pixel_valid_d;

    logic [3:0]       sel_digit;
    logic [5:0]       glyph_bits;
    logic             glyph_bit;

    // Stage 1: split the column into digit index and glyph column.
    always_comb begin
        s1_valid_d   = en;
        s1_row_d     = row;
        s1_dig_d     = col / COL_W'(6);
        s1_gcol_d    = 3'(col % COL_W'(6));
        s1_inrange_d = (32'(col) < 32'(6 * NUM_DIGITS));
    end

    // Stage 2 select: pick the addressed display digit (index 0 = most significant).
    always_comb begin
        sel_digit = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (s1_dig_q == COL_W'(i)) begin
                sel_digit = digits_q[(NUM_DIGITS-1-i)*4 +: 4];
            end
        end
    end

    assign glyph_bits = font_row(sel_digit, s1_row_q);
    assign glyph_bit  = glyph_bits[3'd5 - s1_gcol_q];

`ifdef LEADING_ZERO_BLANK_EN
    logic sel_blank;

    // A digit is blank while no nonzero digit has been seen above it; the last digit always shows.
    always_comb begin
        logic seen_nz;
        seen_nz   = 1'b0;
        sel_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digits_q[(NUM_DIGITS-1-i)*4 +: 4] != 4'd0) begin
                seen_nz = 1'b1;
            end
            if ((s1_dig_q == COL_W'(i)) && !seen_nz && (i != NUM_DIGITS - 1)) begin
                sel_blank = 1'b1;
            end
        end
    end

    // Stage 2 result with leading-zero blanking.
    always_comb begin
        pixel_valid_d = s1_valid_q;
        pixel_d       = s1_valid_q && s1_inrange_q && glyph_bit && !sel_blank;
    end
`else
    // Stage 2 result: out-of-range rows give an all-zero font row.
    always_comb begin
        pixel_valid_d = s1_valid_q;
        pixel_d       = s1_valid_q && s1_inrange_q && glyph_bit;
    end
`endif

    // Pipeline registers for both stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            s1_inrange_q  <= 1'b0;
            s1_row_q      <= '0;
            s1_dig_q      <= '0;
            s1_gcol_q     <= '0;
            pixel_q       <= 1'b0;
            pixel_valid_q <= 1'b0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_inrange_q  <= s1_inrange_d;
            s1_row_q      <= s1_row_d;
            s1_dig_q      <= s1_dig_d;
            s1_gcol_q     <= s1_gcol_d;
            pixel_q       <= pixel_d;
            pixel_valid_q <= pixel_valid_d;
        end
    end

    assign pixel       = pixel_q;
    assign pixel_valid = pixel_valid_q;

endmodule

// File: tb/tb_digit_renderer.sv
// tb_digit_renderer: scoreboard bench for digit_renderer (NUM_DIGITS=4, VALUE_W=14).
module tb_digit_renderer;

    localparam int NUM_DIGITS = 4;
    localparam int VALUE_W    = 14;
    localparam int COL_W      = 5;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               load = 1'b0;
    logic [VALUE_W-1:0] value = '0;
    logic               busy;
    logic               overflow;
    logic               en = 1'b0;
    logic [3:0]         row = '0;
    logic [COL_W-1:0]   col = '0;
    logic               pixel;
    logic               pixel_valid;

    always #5 clk = ~clk;

    digit_renderer #(.NUM_DIGITS(NUM_DIGITS), .VALUE_W(VALUE_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .value       (value),
        .busy        (busy),
        .overflow    (overflow),
        .en          (en),
        .row         (row),
        .col         (col),
        .pixel       (pixel),
        .pixel_valid (pixel_valid)
    );

    typedef struct {
        int   cyc;
        logic pix;
        int   r;
        int   c;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    int   md[NUM_DIGITS];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [5:0] tb_font(input int d, input int r);
        logic [59:0] g;
        case (d)
            0: g = {6'b111111, 6'b110011, 6'b110011, 6'b110111, 6'b111011,
                    6'b110011, 6'b110011, 6'b110011, 6'b110011, 6'b111111};
            1: g = {6'b111100, 6'b001100, 6'b001100, 6'b001100, 6'b001100,
                    6'b001100, 6'b001100, 6'b001100, 6'b001100, 6'b111111};
            2: g = {6'b111111, 6'b000011, 6'b000011, 6'b000011, 6'b111111,
                    6'b110000, 6'b110000, 6'b110000, 6'b110000, 6'b111111};
            3: g = {6'b111111, 6'b000011, 6'b000011, 6'b000011, 6'b011111,
                    6'b000011, 6'b000011, 6'b000011, 6'b000011, 6'b111111};
            4: g = {6'b110011, 6'b110011, 6'b110011, 6'b110011, 6'b111111,
                    6'b000011, 6'b000011, 6'b000011, 6'b000011, 6'b000011};
            5: g = {6'b111111, 6'b110000, 6'b110000, 6'b110000, 6'b111111,
                    6'b000011, 6'b000011, 6'b000011, 6'b000011, 6'b111111};
            6: g = {6'b111111, 6'b110000, 6'b110000, 6'b110000, 6'b111111,
                    6'b110011, 6'b110011, 6'b110011, 6'b110011, 6'b111111};
            7: g = {6'b111111, 6'b000011, 6'b000011, 6'b000110, 6'b001100,
                    6'b001100, 6'b001100, 6'b001100, 6'b001100, 6'b001100};
            8: g = {6'b111111, 6'b110011, 6'b110011, 6'b110011, 6'b111111,
                    6'b110011, 6'b110011, 6'b110011, 6'b110011, 6'b111111};
            default: g = {6'b111111, 6'b110011, 6'b110011, 6'b110011, 6'b111111,
                          6'b000011, 6'b000011, 6'b000011, 6'b000011, 6'b111111};
        endcase
        return g[(9 - r) * 6 +: 6];
    endfunction

    function automatic logic exp_pix(input int r, input int c);
        int d;
        int gc;
        logic [5:0] g;
        if (r > 9 || c >= 6 * NUM_DIGITS) return 1'b0;
        d  = c / 6;
        gc = c % 6;
`ifdef LEADING_ZERO_BLANK_EN
        if (d < NUM_DIGITS - 1) begin
            bit all_zero;
            all_zero = 1'b1;
            for (int i = 0; i <= d; i++) if (md[i] != 0) all_zero = 1'b0;
            if (all_zero) return 1'b0;
        end
`endif
        g = tb_font(md[d], r);
        return g[5 - gc];
    endfunction

    function automatic void set_model(input int v);
        int t;
        t = v;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            md[i] = (v > 9999) ? 9 : (t % 10);
            t = t / 10;
        end
    endfunction

    // Scoreboard monitor: every pixel_valid pops one expected response.
    always @(negedge clk) begin : mon
        exp_t e;
        if (mon_en) begin
            while (sb.size() > 0 && sb[0].cyc + 2 < cyc) begin
                e = sb.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL missing_response r=%0d c=%0d: pixel_valid got 0 want 1", e.r, e.c);
            end
            vectors++;
            if (pixel_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL spurious_valid cyc=%0d: pixel_valid got 1 want 0", cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc + 2 != cyc || pixel !== e.pix) begin
                        miscompares++;
                        $display("FAIL pixel r=%0d c=%0d: got %b at lat %0d, want %b at lat 2",
                                 e.r, e.c, pixel, cyc - e.cyc, e.pix);
                    end
                end
            end else if (pixel !== 1'b0 || pixel_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_pixel cyc=%0d: pixel=%b valid=%b want 0/0", cyc, pixel, pixel_valid);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int r, input int c);
        exp_t e;
        en  = 1'b1;
        row = 4'(r);
        col = COL_W'(c);
        e.cyc = cyc;
        e.pix = exp_pix(r, c);
        e.r   = r;
        e.c   = c;
        sb.push_back(e);
        step();
    endtask

    task automatic idle(input int n);
        en = 1'b0;
        repeat (n) step();
    endtask

    task automatic sweep_row(input int r, input int c0, input int c1);
        for (int c = c0; c <= c1; c++) pix(r, c);
    endtask

    // Pulses load and counts the post-edge samples with busy high (bounded).
    task automatic do_load(input int v, output int n);
        en    = 1'b0;
        value = VALUE_W'(v);
        load  = 1'b1;
        step();
        load = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) step();
        vectors++;
        if (busy !== 1'b0 || overflow !== 1'b0 || pixel !== 1'b0 || pixel_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: busy=%b ovf=%b pix=%b pv=%b want all 0",
                     busy, overflow, pixel, pixel_valid);
        end
        rst_n = 1'b1;
        set_model(0);
        mon_en = 1'b1;
        sweep_row(0, 0, 23);
        sweep_row(2, 0, 5);
        idle(4);
    endtask

    task automatic test_convert();
        int n;
        do_load(1234, n);
        vectors++;
        if (n != 15) begin
            miscompares++;
            $display("FAIL busy_len_1234: got %0d cycles want 15", n);
        end
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow_1234: got %b want 0", overflow);
        end
        set_model(1234);
        pix(0, 6);
        sweep_row(0, 0, 23);
        sweep_row(4, 0, 23);
        sweep_row(9, 0, 23);
        idle(4);
    endtask

    task automatic test_overflow();
        int n;
        do_load(10000, n);
        vectors++;
        if (n != 15 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_10000: busy_len=%0d ovf=%b want 15/1", n, overflow);
        end
        set_model(10000);
        sweep_row(0, 0, 23);
        sweep_row(5, 0, 23);
        idle(3);
        do_load(5, n);
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow_clear: got %b want 0", overflow);
        end
        set_model(5);
        sweep_row(0, 0, 23);
        idle(4);
    endtask

    task automatic test_ignored_load();
        int n;
        int g;
        en    = 1'b0;
        value = VALUE_W'(4321);
        load  = 1'b1;
        step();
        load = 1'b0;
        n = busy ? 1 : 0;
        // Requests during conversion must still see the previous digits (0005).
        pix(0, 18); n += busy ? 1 : 0;
        pix(0, 19); n += busy ? 1 : 0;
        pix(4, 18); n += busy ? 1 : 0;
        en    = 1'b0;
        value = VALUE_W'(9876);
        load  = 1'b1;
        step();
        load = 1'b0;
        n += busy ? 1 : 0;
        g = 0;
        while (busy === 1'b1 && g < 100) begin
            step();
            n += busy ? 1 : 0;
            g++;
        end
        vectors++;
        if (n != 15) begin
            miscompares++;
            $display("FAIL busy_len_ignored: got %0d cycles want 15", n);
        end
        idle(3);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL no_queue: busy got %b want 0", busy);
        end
        set_model(4321);
        sweep_row(0, 0, 23);
        sweep_row(9, 0, 23);
        idle(4);
    endtask

    task automatic test_leading_zero();
        int n;
        do_load(1, n);
        vectors++;
        if (n != 15) begin
            miscompares++;
            $display("FAIL busy_len_1: got %0d cycles want 15", n);
        end
        set_model(1);
        sweep_row(0, 0, 23);
        sweep_row(2, 0, 5);
        sweep_row(9, 18, 23);
        idle(4);
    endtask

    task automatic test_out_of_range();
        pix(12, 0);
        pix(12, 20);
        pix(0, 24);
        pix(5, 31);
        pix(10, 7);
        idle(1);
        pix(15, 3);
        pix(9, 23);
        pix(0, 18);
        idle(4);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 30; i++) begin
            pix(int'($urandom_range(0, 11)), int'($urandom_range(0, 26)));
        end
        idle(4);
    endtask

    task automatic test_reset_mid_shift();
        int g;
        mon_en = 1'b0;
        en     = 1'b1;
        row    = 4'd0;
        col    = COL_W'(18);
        value  = VALUE_W'(9999);
        load   = 1'b1;
        step();
        load = 1'b0;
        repeat (5) step();
        vectors++;
        if (busy !== 1'b1 || pixel !== 1'b1 || pixel_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset: busy=%b pix=%b pv=%b want 1/1/1", busy, pixel, pixel_valid);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || pixel !== 1'b0 || pixel_valid !== 1'b0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: busy=%b pix=%b pv=%b ovf=%b want all 0",
                     busy, pixel, pixel_valid, overflow);
        end
        en = 1'b0;
        step();
        sb.delete();
        set_model(0);
        rst_n  = 1'b1;
        value  = VALUE_W'(42);
        load   = 1'b1;
        mon_en = 1'b1;
        step();
        load = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL load_after_reset: busy got %b want 1", busy);
        end
        sweep_row(0, 0, 11);
        en = 1'b0;
        g = 0;
        while (busy === 1'b1 && g < 100) begin
            step();
            g++;
        end
        vectors++;
        if (g == 100) begin
            miscompares++;
            $display("FAIL busy_timeout_42: busy got 1 want 0");
        end
        set_model(42);
        sweep_row(0, 0, 23);
        sweep_row(2, 0, 23);
        idle(4);
    endtask

    initial begin
        test_reset();
        test_convert();
        test_overflow();
        test_ignored_load();
        test_leading_zero();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_shift();
        idle(2);
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
